stack_sequencer: RTL and testbench

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_stack_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer
//
// Moves a masked set of register-file slots to or from a word-addressed stack,
// one bus beat per set mask bit. Push visits set bits lowest-first, pre-
// decrements SP by 2 and writes the slot value. Pop visits set bits
// highest-first, reads at SP, writes the slot and post-increments SP by 2.
// The slot at index SP_IDX is the stack pointer itself. A push stores the SP
// value latched at start. A pop skips the register write for that slot, but
// the address still advances.
//
// Handshake: mem_req is held high, with mem_addr, mem_wdata and mem_wr held
// stable, until a cycle in which mem_ack is also high. That cycle completes
// the beat. mem_ack is ignored while mem_req is low.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start, mode, mask,  sequence request (mode 0 = push, 1 = pop), sampled
//   sp_in               only in IDLE
//   reg_sel, reg_rdata  register-file read port (reg_rdata is combinational)
//   reg_we, reg_wdata   register-file write port (pop only)
//   mem_req, mem_wr,    stack bus request / direction / address / data
//   mem_addr, mem_wdata
//   mem_rdata, mem_ack  stack bus read data / beat acknowledge
//   busy                high exactly while beats are being issued
//   done, sp_out        one-cycle completion pulse with the final SP
//   dbg_state_o         current FSM state, for observation only
module stack_sequencer #(
  parameter int MASK_W = 16,
  parameter int DATA_W = 16,
  parameter int SP_IDX = 4,
  localparam int SEL_W = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [MASK_W-1:0] mask,
  input  logic [DATA_W-1:0] sp_in,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sp_out,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [SEL_W-1:0]  SP_SEL = SEL_W'(SP_IDX);
  localparam logic [DATA_W-1:0] TWO    = DATA_W'(2);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [MASK_W-1:0] mask_q, mask_d;   // slots still to transfer
  logic [DATA_W-1:0] sp_q, sp_d;       // running stack pointer
  logic [DATA_W-1:0] sp_in_q, sp_in_d; // SP at start, pushed for slot SP_IDX
  logic [DATA_W-1:0] sp_out_q, sp_out_d;

  logic [SEL_W-1:0]  slot;
  logic [MASK_W-1:0] slot_oh;
  logic [MASK_W-1:0] mask_rest;
  logic [DATA_W-1:0] sp_dec;
  logic [DATA_W-1:0] sp_next;
  logic              in_xfer;
  logic              slot_is_sp;

  // Pick the current slot. In push mode the loop runs high-to-low, so the
  // last match written is the lowest set bit. In pop mode it runs
  // low-to-high, so the last match written is the highest set bit.
  always_comb begin
    slot = '0;
    if (!mode_q) begin
      for (int i = MASK_W - 1; i >= 0; i--) begin
        if (mask_q[i]) slot = SEL_W'(i);
      end
    end else begin
      for (int i = 0; i < MASK_W; i++) begin
        if (mask_q[i]) slot = SEL_W'(i);
      end
    end
  end

  always_comb begin
    slot_oh = '0;
    for (int i = 0; i < MASK_W; i++) begin
      slot_oh[i] = (SEL_W'(i) == slot);
    end
  end

  assign mask_rest  = mask_q & ~slot_oh;
  assign sp_dec     = sp_q - TWO;   // modulo 2^DATA_W
  assign sp_next    = mode_q ? (sp_q + TWO) : sp_dec;
  assign in_xfer    = (state_q == XFER);
  assign slot_is_sp = (slot == SP_SEL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      mask_q   <= '0;
      sp_q     <= '0;
      sp_in_q  <= '0;
      sp_out_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      sp_q     <= sp_d;
      sp_in_q  <= sp_in_d;
      sp_out_q <= sp_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    sp_d     = sp_q;
    sp_in_d  = sp_in_q;
    sp_out_d = sp_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          mask_d  = mask;
          sp_d    = sp_in;
          sp_in_d = sp_in;
          if (mask == '0) begin
            state_d  = DONE;
            sp_out_d = sp_in;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (mem_ack) begin
          mask_d = mask_rest;
          sp_d   = sp_next;
          if (mask_rest == '0) begin
            state_d  = DONE;
            sp_out_d = sp_next;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The outputs are decoded from registered state. They stay constant for the
  // whole beat while mem_ack is low. reg_we and reg_wdata are the exception:
  // they follow mem_ack and mem_rdata combinationally.
  always_comb begin
    reg_sel   = in_xfer ? slot : '0;
    mem_req   = in_xfer;
    mem_wr    = in_xfer & ~mode_q;
    mem_addr  = '0;
    mem_wdata = '0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    if (in_xfer) begin
      if (!mode_q) begin
        mem_addr  = sp_dec;
        mem_wdata = slot_is_sp ? sp_in_q : reg_rdata;
      end else begin
        mem_addr  = sp_q;
        reg_wdata = mem_rdata;
        reg_we    = mem_ack & ~slot_is_sp;
      end
    end
  end

  assign busy        = in_xfer;
  assign done        = (state_q == DONE);
  assign sp_out      = sp_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [15:0] mask;
  logic [15:0] sp_in;
  logic [3:0]  reg_sel;
  logic [15:0] reg_rdata;
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic [15:0] sp_out;
  logic [1:0]  dbg_state;

  logic [15:0] rf [16];
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign reg_rdata = rf[reg_sel];

  stack_sequencer #(.MASK_W(16), .DATA_W(16), .SP_IDX(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .mask(mask),
    .sp_in(sp_in), .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we),
    .reg_wdata(reg_wdata), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .sp_out(sp_out),
    .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic m, input logic [15:0] mk, input logic [15:0] sp, input logic ack);
    start   = 1'b1;
    mode    = m;
    mask    = mk;
    sp_in   = sp;
    mem_ack = ack;
  endtask

  initial begin
    int nbeats;
    int nwe;
    bit got_done;
    logic [15:0] e;

    for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; mask = '0; sp_in = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    #3;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_spout", sp_out, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_sel", reg_sel, 0);
    step();
    step();

    // Push all. Reset is released and start is presented in the same cycle,
    // so the very next edge must accept the start.
    reset_n = 1'b1;
    go(1'b0, 16'h00FF, 16'h1000, 1'b1);
    step();
    start = 1'b0;
    chk("push_busy", busy, 1);
    chk("push_wr", mem_wr, 1);
    for (int k = 0; k < 8; k++) begin
      chk("push_req", mem_req, 1);
      chk("push_sel", reg_sel, k);
      chk("push_addr", mem_addr, 16'h0FFE - 16'(2 * k));
      chk("push_wdata", mem_wdata, (k == 4) ? 16'h1000 : 16'hA000 + 16'(k));
      chk("push_we", reg_we, 0);
      step();
    end
    chk("push_done", done, 1);
    chk("push_done_busy", busy, 0);
    chk("push_done_req", mem_req, 0);
    chk("push_spout", sp_out, 16'h0FF0);
    step();
    chk("push_done_pulse", done, 0);

    // Pop all
    go(1'b1, 16'h00FF, 16'h0FF0, 1'b1);
    step();
    start = 1'b0;
    nwe = 0;
    for (int k = 0; k < 8; k++) begin
      mem_rdata = 16'hB000 + 16'(7 - k);
      #1;
      chk("pop_sel", reg_sel, 7 - k);
      chk("pop_addr", mem_addr, 16'h0FF0 + 16'(2 * k));
      chk("pop_wr", mem_wr, 0);
      chk("pop_we", reg_we, (7 - k) != 4);
      if (reg_we) begin
        nwe++;
        chk("pop_wdata", reg_wdata, 16'hB000 + 16'(7 - k));
      end
      step();
    end
    chk("pop_we_count", nwe, 7);
    chk("pop_done", done, 1);
    chk("pop_spout", sp_out, 16'h1000);
    step();

    // Wait states: one-bit push, ack withheld for 3 cycles
    go(1'b0, 16'h0004, 16'h2000, 1'b0);
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ws_req", mem_req, 1);
      chk("ws_addr", mem_addr, 16'h1FFE);
      chk("ws_wdata", mem_wdata, 16'hA002);
      step();
    end
    mem_ack = 1'b1;
    #1;
    chk("ws_req4", mem_req, 1);
    chk("ws_addr4", mem_addr, 16'h1FFE);
    step();
    chk("ws_done", done, 1);
    chk("ws_spout", sp_out, 16'h1FFE);
    // ack held high while idle is ignored
    step();
    chk("ws_idle_req", mem_req, 0);
    chk("ws_idle_we", reg_we, 0);
    step();
    chk("ws_idle_busy", busy, 0);
    mem_ack = 1'b0;

    // Empty mask
    go(1'b0, 16'h0000, 16'h1234, 1'b0);
    step();
    start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_req", mem_req, 0);
    chk("empty_busy", busy, 0);
    chk("empty_spout", sp_out, 16'h1234);
    step();

    // Push wrap below zero
    go(1'b0, 16'h0001, 16'h0000, 1'b1);
    step();
    start = 1'b0;
    chk("wrap_push_addr", mem_addr, 16'hFFFE);
    chk("wrap_push_wdata", mem_wdata, 16'hA000);
    step();
    chk("wrap_push_done", done, 1);
    chk("wrap_push_spout", sp_out, 16'hFFFE);
    step();

    // Pop wrap above 0xFFFE
    go(1'b1, 16'h0001, 16'hFFFE, 1'b1);
    step();
    start = 1'b0;
    chk("wrap_pop_addr", mem_addr, 16'hFFFE);
    step();
    chk("wrap_pop_spout", sp_out, 16'h0000);
    step();

    // Reset in the middle of a 4-beat push, after the second ack
    go(1'b0, 16'h000F, 16'h3000, 1'b1);
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_addr_pre", mem_addr, 16'h2FFA);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sel", reg_sel, 0);
    chk("mid_rst_addr", mem_addr, 0);
    step();
    chk("mid_rst_req2", mem_req, 0);
    reset_n = 1'b1;
    go(1'b0, 16'h0003, 16'h4000, 1'b1);
    step();
    start = 1'b0;
    chk("fresh_addr0", mem_addr, 16'h3FFE);
    step();
    chk("fresh_addr1", mem_addr, 16'h3FFC);
    chk("fresh_wdata1", mem_wdata, 16'hA001);
    step();
    chk("fresh_done", done, 1);
    chk("fresh_spout", sp_out, 16'h3FFC);
    step();

    // Start pulsed while busy must be ignored
    go(1'b0, 16'h0007, 16'h5000, 1'b0);
    step();
    go(1'b1, 16'hFFFF, 16'h0000, 1'b0);
    #1;
    chk("bs_wr", mem_wr, 1);
    chk("bs_addr", mem_addr, 16'h4FFE);
    step();
    start = 1'b0;
    mem_ack = 1'b1;
    exp_q.push_back(16'h4FFE);
    exp_q.push_back(16'h4FFC);
    exp_q.push_back(16'h4FFA);
    nbeats = 0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (mem_req && mem_ack) begin
        nbeats++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        chk("bs_beat_addr", mem_addr, e);
        chk("bs_beat_wr", mem_wr, 1);
      end
      step();
    end
    chk("bs_got_done", got_done, 1);
    chk("bs_beats", nbeats, 3);
    chk("bs_spout", sp_out, 16'h4FFA);
    mem_ack = 1'b0;
    step();
    chk("bs_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
